// File: rtl/mips_pkg.sv
// Shared MiniMIPS constants used by the fetch unit, the instruction memory
// and decode. All values are defaults; each module takes them as parameters.
//   DEF_PC_W       : width of the PC / instruction-memory word address
//   DEF_INSTR_W    : instruction width
//   DEF_IMEM_DEPTH : number of instruction-memory words (valid 0..DEPTH-1)
//   DEF_RESET_PC   : word address fetched first after reset
package mips_pkg;

  localparam int          DEF_PC_W       = 32;
  localparam int          DEF_INSTR_W    = 16;
  localparam int          DEF_IMEM_DEPTH = 35;
  localparam int unsigned DEF_RESET_PC   = 0;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Skid register for the fetched instruction word.
// The synchronous memory keeps reading the current address while decode is
// stalled, so the word belonging to the presented instruction would be lost
// after the first stalled edge. This buffer catches that word once and
// presents it until the stall ends.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   capture  : take din into the hold register (ignored while already holding)
//   clear    : drop the held word (has priority over capture)
//   din      : instruction word coming from the memory
//   dout     : held word when holding, otherwise din
module fetch_skid_buffer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] hold_instr;
  logic         hold_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_instr <= '0;
      hold_valid <= 1'b0;
    end else if (clear) begin
      hold_valid <= 1'b0;
    end else if (capture && !hold_valid) begin
      // Only the first stalled edge sees the presented word on din; later
      // edges see the next address's word and must not overwrite it.
      hold_instr <= din;
      hold_valid <= 1'b1;
    end
  end

  assign dout = hold_valid ? hold_instr : din;

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch initiator for the 16-bit MiniMIPS core.
// Owns the PC, issues word addresses to a synchronous instruction memory
// (address sampled at posedge, data one cycle later) and presents
// {if_instr, if_pc, if_valid} to decode. Supports decode stall, branch/jump
// redirect and sticky detection of fetches beyond the end of memory.
// Ports:
//   clk, rst        : clock and asynchronous active-high reset
//   imem_addr       : word address to instruction memory (registered)
//   imem_data       : memory word for the address sampled on the last edge
//   stall           : decode cannot accept, hold current output
//   redirect_valid  : taken branch/jump this cycle
//   redirect_pc     : redirect target word address
//   if_valid        : if_instr/if_pc carry a real instruction
//   if_instr        : fetched instruction
//   if_pc           : word address of if_instr
//   fetch_fault     : sticky, fetch ran past memory and is halted
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int              PC_W       = DEF_PC_W,
  parameter int              INSTR_W    = DEF_INSTR_W,
  parameter int              IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               fetch_fault
);

  localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight_valid;
  logic            fault;

  logic            issue_ok;
  logic            in_range;
  logic            skid_capture;
  logic            skid_clear;

  // Redirect overrides everything; otherwise a halted or stalled fetch stays put.
  assign issue_ok = !redirect_valid && !fault && !stall;
  assign in_range = (pc_q < DEPTH_PC);

  // Address issue stage: pc_q is what the memory samples on each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight_pc    <= '0;
      inflight_valid <= 1'b0;
      fault          <= 1'b0;
    end else if (redirect_valid) begin
      // The word arriving next cycle belongs to the old path: one bubble.
      pc_q           <= redirect_pc;
      inflight_valid <= 1'b0;
      fault          <= 1'b0;
    end else if (issue_ok) begin
      if (in_range) begin
        inflight_pc    <= pc_q;
        inflight_valid <= 1'b1;
        pc_q           <= pc_q + PC_W'(1);
      end else begin
        // pc_q is held so imem_addr shows the offending address.
        fault          <= 1'b1;
        inflight_valid <= 1'b0;
      end
    end
  end

  // Data return stage: memory word lines up with inflight_pc.
  assign skid_capture = stall && !redirect_valid && !fault && inflight_valid;
  assign skid_clear   = redirect_valid || !stall;

  fetch_skid_buffer #(
    .W (INSTR_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .capture (skid_capture),
    .clear   (skid_clear),
    .din     (imem_data),
    .dout    (if_instr)
  );

  assign imem_addr   = pc_q;
  assign if_valid    = inflight_valid;
  assign if_pc       = inflight_pc;
  assign fetch_fault = fault;

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;

  localparam int DEPTH = 35;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  int compared   = 0;
  int mismatched = 0;

  // Reference view of the fetch stream.
  logic [31:0] m_next;    // next address to be fetched
  logic        m_valid;   // an instruction is presented
  logic [31:0] m_pc;      // address of the presented instruction
  logic        m_fault;

  mips_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [31:0] a);
    if (a < DEPTH) return 16'hA000 + a[15:0];
    return 16'hDEAD;
  endfunction

  // Synchronous instruction memory: address sampled at posedge.
  always @(posedge clk) imem_data <= mem_word(imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_next  = 32'd0;
    m_valid = 1'b0;
    m_pc    = 32'd0;
    m_fault = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  imem_addr, m_next);
    chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, m_fault});
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    if (m_valid) begin
      chk({tag, ".pc"},    if_pc, m_pc);
      chk({tag, ".instr"}, {16'd0, if_instr}, {16'd0, mem_word(m_pc)});
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".addr"},  imem_addr, 32'd0);
    chk({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, ".pc"},    if_pc, 32'd0);
    chk({tag, ".fault"}, {31'd0, fetch_fault}, 32'd0);
  endtask

  // One clock: apply inputs (called at negedge), advance the model by the
  // fetch rules for the edge, then check at the following negedge.
  task automatic cyc(input string tag, input logic s, input logic r, input logic [31:0] t);
    stall          = s;
    redirect_valid = r;
    redirect_pc    = t;
    @(posedge clk);
    if (r) begin
      m_next  = t;
      m_valid = 1'b0;
      m_fault = 1'b0;
    end else if (!m_fault && !s) begin
      if (m_next < DEPTH) begin
        m_pc    = m_next;
        m_valid = 1'b1;
        m_next  = m_next + 32'd1;
      end else begin
        m_fault = 1'b1;
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Sequential fetch from reset: if_pc 0..5
    for (int i = 0; i < 6; i++) cyc("seq", 1'b0, 1'b0, 32'd0);
    chk("seq.pc5", if_pc, 32'd5);

    // Stall three cycles while presenting 5, then release
    for (int i = 0; i < 3; i++) begin
      cyc("stall", 1'b1, 1'b0, 32'd0);
      chk("stall.frozen_instr", {16'd0, if_instr}, 32'h0000A005);
    end
    cyc("release", 1'b0, 1'b0, 32'd0);
    chk("release.pc6", if_pc, 32'd6);
    cyc("release", 1'b0, 1'b0, 32'd0);
    chk("release.pc7", if_pc, 32'd7);

    // Restart at 0, redirect to 20 while presenting 3
    cyc("restart", 1'b0, 1'b1, 32'd0);
    for (int i = 0; i < 4; i++) cyc("restart", 1'b0, 1'b0, 32'd0);
    chk("redir.pc3", if_pc, 32'd3);
    cyc("redir", 1'b0, 1'b1, 32'd20);
    chk("redir.bubble", {31'd0, if_valid}, 32'd0);
    cyc("redir", 1'b0, 1'b0, 32'd0);
    chk("redir.pc20", if_pc, 32'd20);
    cyc("redir", 1'b0, 1'b0, 32'd0);
    chk("redir.pc21", if_pc, 32'd21);

    // Run off the end of memory
    for (int i = 0; i < 16; i++) cyc("run", 1'b0, 1'b0, 32'd0);
    chk("end.pc34", if_pc, 32'd34);
    for (int i = 0; i < 4; i++) cyc("fault", 1'b0, 1'b0, 32'd0);
    chk("fault.sticky", {31'd0, fetch_fault}, 32'd1);
    chk("fault.addr35", imem_addr, 32'd35);
    cyc("fault_clear", 1'b0, 1'b1, 32'd0);
    chk("fault.cleared", {31'd0, fetch_fault}, 32'd0);
    cyc("fault_clear", 1'b0, 1'b0, 32'd0);
    chk("fault.restart0", if_pc, 32'd0);

    // Stall and redirect in the same cycle
    cyc("stall_redir", 1'b1, 1'b1, 32'd10);
    cyc("stall_redir", 1'b0, 1'b0, 32'd0);
    chk("stall_redir.pc10", if_pc, 32'd10);
    chk("stall_redir.instr", {16'd0, if_instr}, 32'h0000A00A);

    // Redirect to an out-of-range target faults on the following edge
    cyc("oor", 1'b0, 1'b1, 32'd40);
    cyc("oor", 1'b0, 1'b0, 32'd0);
    chk("oor.fault", {31'd0, fetch_fault}, 32'd1);

    // Asynchronous reset in the middle of a stall with a held word
    cyc("pre_rst", 1'b0, 1'b1, 32'd4);
    cyc("pre_rst", 1'b0, 1'b0, 32'd0);
    cyc("pre_rst", 1'b1, 1'b0, 32'd0);
    cyc("pre_rst", 1'b1, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    model_reset();
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("async_rst_hold");
    cyc("after_rst", 1'b0, 1'b0, 32'd0);
    chk("after_rst.pc0", if_pc, 32'd0);
    cyc("after_rst", 1'b0, 1'b0, 32'd0);

    // Randomized stall / redirect traffic
    for (int i = 0; i < 600; i++) begin
      logic        s, r;
      logic [31:0] t;
      s = ($urandom_range(0, 99) < 30);
      r = ($urandom_range(0, 99) < 8);
      t = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 40));
      cyc("rand", s, r, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
